// File: rtl/gem_pad_es_sched_if.sv
// gem_pad_es_sched_if: batch strobe, ROM ports and results bundle
// master = cluster decoder / ROM side, slave = sequencer
interface gem_pad_es_sched_if #(
  parameter int MXCL   = 8,
  parameter int MXADRB = 8,
  parameter int MXDATB = 10
);
  logic                     start;
  logic [MXCL-1:0]          pad_vld;
  logic [MXCL*MXADRB-1:0]   pad_adr;
  logic [MXADRB-1:0]        rom_adr0;
  logic [MXADRB-1:0]        rom_adr1;
  logic [MXDATB-1:0]        rom_rd0;
  logic [MXDATB-1:0]        rom_rd1;
  logic [MXCL*MXDATB-1:0]   es_out;
  logic [MXCL-1:0]          es_vld;
  logic                     busy;
  logic                     done;
  logic                     overrun;
  logic [MXCL-1:0]          oor_err;

  modport master (
    output start, pad_vld, pad_adr,
    output rom_rd0, rom_rd1,
    input  rom_adr0, rom_adr1,
    input  es_out, es_vld, busy,
    input  done, overrun, oor_err
  );

  modport slave (
    input  start, pad_vld, pad_adr,
    input  rom_rd0, rom_rd1,
    output rom_adr0, rom_adr1,
    output es_out, es_vld, busy,
    output done, overrun, oor_err
  );
endinterface

// File: rtl/gem_pad_es_sched.sv
// gem_pad_es_sched: pairwise pad->eighth-strip ROM lookup sequencer.
// Optional pad range check enabled by GEM_PAD_ES_RANGE_CHECK_EN.
module gem_pad_es_sched #(
  parameter int MXCL      = 8,
  parameter int MXADRB    = 8,
  parameter int MXDATB    = 10,
  parameter int ROMLENGTH = 192
) (
  input logic               clock,
  input logic               reset,
  gem_pad_es_sched_if.slave bus
);
  localparam int NP = MXCL / 2;
  localparam int CW = $clog2(NP + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  if ((MXCL % 2) != 0 || ROMLENGTH > (1 << MXADRB)) begin : g_bad_cfg
    $error("gem_pad_es_sched: MXCL must be even, ROMLENGTH <= 2**MXADRB");
  end

`ifdef GEM_PAD_ES_RANGE_CHECK_EN
  localparam logic [MXADRB:0] ROMLEN = ROMLENGTH[MXADRB:0];

  function automatic logic ok(input logic v,
                              input logic [MXADRB-1:0] a);
    return v && ({1'b0, a} < ROMLEN);
  endfunction
`else
  function automatic logic ok(input logic v,
                              input logic [MXADRB-1:0] a);
    return v;
  endfunction
`endif

  function automatic logic [MXADRB-1:0] iss(input logic v,
                                            input logic [MXADRB-1:0] a);
    return ok(v, a) ? a : '0;
  endfunction

  logic [1:0]             state;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cidx;
  logic                   cap;
  logic [MXCL*MXADRB-1:0] pad_q;
  logic [MXCL-1:0]        vld_q;
  logic [MXADRB-1:0]      adr0_q;
  logic [MXADRB-1:0]      adr1_q;
  logic [MXADRB-1:0]      nxt0;
  logic [MXADRB-1:0]      nxt1;
  logic [MXCL*MXDATB-1:0] es_q;
  logic [MXCL-1:0]        esv_q;
  logic [MXCL-1:0]        oor_q;
  logic                   done_q;
  logic                   ovr_q;

  // read data for the pair issued last cycle arrives now
  assign cap  = (state == ISSUE && cnt != '0) || state == DRAIN;
  assign cidx = cnt - CW'(1);

  // addresses of the pair following the one now on the ROM ports
  always_comb begin
    nxt0 = '0;
    nxt1 = '0;
    for (int k = 0; k < NP; k++) begin
      if (cnt + CW'(1) == CW'(k)) begin
        nxt0 = iss(vld_q[2*k],
                   pad_q[2*k*MXADRB +: MXADRB]);
        nxt1 = iss(vld_q[2*k+1],
                   pad_q[(2*k+1)*MXADRB +: MXADRB]);
      end
    end
  end

  // batch FSM, ROM address issue and result capture
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      pad_q  <= '0;
      vld_q  <= '0;
      adr0_q <= '0;
      adr1_q <= '0;
      es_q   <= '0;
      esv_q  <= '0;
      oor_q  <= '0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ovr_q  <= bus.start && (state != IDLE);
      if (cap) begin
        for (int i = 0; i < MXCL; i++) begin
          if (CW'(i / 2) == cidx) begin
            esv_q[i] <= ok(vld_q[i],
                           pad_q[i*MXADRB +: MXADRB]);
            es_q[i*MXDATB +: MXDATB] <=
              !ok(vld_q[i], pad_q[i*MXADRB +: MXADRB]) ? '0 :
              ((i % 2) == 0) ? bus.rom_rd0 : bus.rom_rd1;
`ifdef GEM_PAD_ES_RANGE_CHECK_EN
            oor_q[i] <= vld_q[i] &&
                        !ok(1'b1, pad_q[i*MXADRB +: MXADRB]);
`endif
          end
        end
      end
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= ISSUE;
            cnt    <= '0;
            pad_q  <= bus.pad_adr;
            vld_q  <= bus.pad_vld;
            es_q   <= '0;
            esv_q  <= '0;
            oor_q  <= '0;
            adr0_q <= iss(bus.pad_vld[0],
                          bus.pad_adr[0 +: MXADRB]);
            adr1_q <= iss(bus.pad_vld[1],
                          bus.pad_adr[MXADRB +: MXADRB]);
          end
        end
        ISSUE: begin
          cnt    <= cnt + CW'(1);
          adr0_q <= nxt0;
          adr1_q <= nxt1;
          if (cnt == CW'(NP - 1)) state <= DRAIN;
        end
        DRAIN: begin
          state  <= IDLE;
          cnt    <= '0;
          done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rom_adr0 = adr0_q;
  assign bus.rom_adr1 = adr1_q;
  assign bus.es_out   = es_q;
  assign bus.es_vld   = esv_q;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.overrun  = ovr_q;
  assign bus.oor_err  = oor_q;
endmodule
